// File: rtl/pulse_train_ctrl_pkg.sv
// Shared pulse-train definitions.
// Holds the FSM state encoding and the default field widths used by
// pulse_train_ctrl and its phase_counter.
package pulse_train_defs;

  localparam int DEFAULT_HALF_W = 16;
  localparam int DEFAULT_NUM_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_train_ctrl_phase_counter.sv
// phase_counter: loadable down-counter with a zero flag.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset, clears the count
//   load     - load load_val (has priority over en)
//   load_val - value to load
//   en       - decrement by one; ignored when the count is already zero
//   zero     - high while the count equals zero
module phase_counter
  import pulse_train_defs::*;
#(
  parameter int W = DEFAULT_HALF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  assign zero = (count == '0);

  // Load wins over decrement; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pulse_train_ctrl.sv
// pulse_train_ctrl: command-driven pulse train sequencer.
// Accepts (half-period, pulse count) over a valid/ready handshake and drives
// a registered toggle output with busy/done/aborted status.
// Ports:
//   clk, rst           - clock and asynchronous active-high reset
//   cmd_valid/cmd_ready - command handshake; ready only in IDLE
//   cmd_half           - cycles per high and per low phase (0 acts as 1)
//   cmd_num            - number of full pulses (0 completes immediately)
//   abort              - ends a running train on the next edge
//   out                - registered toggle output
//   busy               - high while the train is running
//   done               - one-cycle completion strobe
//   aborted            - qualifies done when the train was aborted
module pulse_train_ctrl
  import pulse_train_defs::*;
#(
  parameter int HALF_W = DEFAULT_HALF_W,
  parameter int NUM_W  = DEFAULT_NUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [HALF_W-1:0] cmd_half,
  input  logic [NUM_W-1:0]  cmd_num,
  input  logic              abort,
  output logic              out,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  state_t             state;
  logic [HALF_W-1:0]  half_reg;
  logic [NUM_W-1:0]   remaining;

  logic               accept;
  logic [HALF_W-1:0]  half_eff;
  logic               ph_load;
  logic [HALF_W-1:0]  ph_load_val;
  logic               ph_en;
  logic               ph_zero;

  assign cmd_ready = (state == IDLE);

  // Decide what the phase counter does this cycle. It is loaded with half-1
  // on accept and on every phase change, and counts down otherwise. An abort
  // freezes it, since the train is ending anyway.
  always_comb begin
    accept      = cmd_valid && cmd_ready;
    half_eff    = (cmd_half == '0) ? HALF_W'(1) : cmd_half;
    ph_load     = 1'b0;
    ph_load_val = half_reg - HALF_W'(1);
    ph_en       = 1'b0;
    if (accept && (cmd_num != '0)) begin
      ph_load     = 1'b1;
      ph_load_val = half_eff - HALF_W'(1);
    end else if ((state == RUN) && !abort) begin
      if (!ph_zero) begin
        ph_en = 1'b1;
      end else if (out || (remaining > NUM_W'(1))) begin
        ph_load = 1'b1;
      end
    end
  end

  phase_counter #(
    .W (HALF_W)
  ) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_load_val),
    .en       (ph_en),
    .zero     (ph_zero)
  );

  // Main sequencer. When a phase expires: a high phase always falls to low;
  // a low phase either starts the next pulse or, on the last pulse, ends the
  // train. Abort overrides all counting on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      half_reg  <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          aborted <= 1'b0;
          if (accept) begin
            if (cmd_num != '0) begin
              half_reg  <= half_eff;
              remaining <= cmd_num;
              out       <= 1'b1;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (abort) begin
            out     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
            state   <= DONE;
          end else if (ph_zero) begin
            if (out) begin
              out <= 1'b0;
            end else if (remaining > NUM_W'(1)) begin
              remaining <= remaining - NUM_W'(1);
              out       <= 1'b1;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          aborted <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          out     <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          aborted <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Testbench for pulse_train_ctrl: directed commands with hand-computed
// expected output patterns and status strobes.
module tb_pulse_train_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_half;
  logic [7:0]  cmd_num;
  logic        abort;
  logic        out;
  logic        busy;
  logic        done;
  logic        aborted;

  int checks;
  int failures;

  pulse_train_ctrl #(
    .HALF_W (16),
    .NUM_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_half  (cmd_half),
    .cmd_num   (cmd_num),
    .abort     (abort),
    .out       (out),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command in IDLE; returns 1 unit after the accept edge E0.
  task automatic applyStimulus(input logic [15:0] h, input logic [7:0] n);
    cmd_valid = 1'b1;
    cmd_half  = h;
    cmd_num   = n;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    logic [11:0] exp12;
    logic [3:0]  exp4;
    int          cycles;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_half  = '0;
    cmd_num   = '0;
    abort     = 1'b0;

    // Reset values before any clock edge
    #2;
    checkOutput("rst_out", out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_aborted", aborted, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // half=3, num=2
    $display("[TB] half=3 num=2");
    exp12 = 12'b111000111000;
    applyStimulus(16'd3, 8'd2);
    for (int k = 0; k < 12; k++) begin
      checkOutput("t2_out", out, exp12[11-k]);
      checkOutput("t2_done", done, 0);
      tick();
    end
    checkOutput("t2_done_strobe", done, 1);
    checkOutput("t2_aborted", aborted, 0);
    checkOutput("t2_out_end", out, 0);
    checkOutput("t2_busy_end", busy, 0);
    checkOutput("t2_ready_in_done", cmd_ready, 0);
    tick();
    checkOutput("t2_ready_back", cmd_ready, 1);
    checkOutput("t2_done_clear", done, 0);

    // half=0 acts as half=1
    $display("[TB] half=0 num=1");
    applyStimulus(16'd0, 8'd1);
    checkOutput("t3_out_hi", out, 1);
    tick();
    checkOutput("t3_out_lo", out, 0);
    checkOutput("t3_done_early", done, 0);
    tick();
    checkOutput("t3_done", done, 1);
    checkOutput("t3_aborted", aborted, 0);
    tick();
    checkOutput("t3_ready", cmd_ready, 1);

    // num=0 completes immediately
    $display("[TB] num=0");
    applyStimulus(16'd5, 8'd0);
    checkOutput("t4_done", done, 1);
    checkOutput("t4_aborted", aborted, 0);
    checkOutput("t4_out", out, 0);
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_ready", cmd_ready, 0);
    tick();
    checkOutput("t4_done_clear", done, 0);
    checkOutput("t4_ready_back", cmd_ready, 1);
    checkOutput("t4_busy_after", busy, 0);

    // Abort in IDLE has no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("idle_abort_done", done, 0);
    checkOutput("idle_abort_aborted", aborted, 0);
    checkOutput("idle_abort_ready", cmd_ready, 1);

    // half=4 num=5, abort sampled at E0+6, next command held during RUN
    $display("[TB] abort at E0+6");
    applyStimulus(16'd4, 8'd5);
    checkOutput("t5_busy", busy, 1);
    tick();
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_half  = 16'd1;
    cmd_num   = 8'd1;
    tick();
    tick();
    checkOutput("t5_ready_run", cmd_ready, 0);
    checkOutput("t5_busy_run", busy, 1);
    checkOutput("t5_out_e5", out, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t5_out_abort", out, 0);
    checkOutput("t5_done_abort", done, 1);
    checkOutput("t5_aborted", aborted, 1);
    checkOutput("t5_busy_abort", busy, 0);
    checkOutput("t5_ready_done", cmd_ready, 0);
    tick();
    checkOutput("t5_done_clear", done, 0);
    checkOutput("t5_aborted_clear", aborted, 0);
    checkOutput("t5_ready_back", cmd_ready, 1);
    checkOutput("t5_not_yet", busy, 0);
    tick();
    cmd_valid = 1'b0;
    checkOutput("t5_accept_busy", busy, 1);
    checkOutput("t5_accept_out", out, 1);
    tick();
    checkOutput("t5_next_lo", out, 0);
    tick();
    checkOutput("t5_next_done", done, 1);
    checkOutput("t5_next_aborted", aborted, 0);
    tick();

    // Abort while out is high drops it at once
    $display("[TB] abort during high phase");
    applyStimulus(16'd4, 8'd5);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t5b_out", out, 0);
    checkOutput("t5b_done", done, 1);
    checkOutput("t5b_aborted", aborted, 1);
    tick();

    // Reset mid-train, then a fresh command
    $display("[TB] reset mid-train");
    applyStimulus(16'd2, 8'd3);
    tick();
    tick();
    tick();
    tick();
    checkOutput("t6_out_pre", out, 1);
    checkOutput("t6_busy_pre", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_out", out, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_done", done, 0);
    checkOutput("t6_rst_ready", cmd_ready, 1);
    tick();
    checkOutput("t6_no_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("t6_idle_done", done, 0);
    checkOutput("t6_idle_ready", cmd_ready, 1);
    exp4 = 4'b1010;
    applyStimulus(16'd1, 8'd2);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t6_out", out, exp4[3-k]);
      checkOutput("t6_done_low", done, 0);
      tick();
    end
    checkOutput("t6_done", done, 1);
    tick();

    // Maximum pulse count: done at E0 + 2*1*255 = E0+510
    $display("[TB] num=255");
    applyStimulus(16'd1, 8'd255);
    cycles = 0;
    while (!done && cycles < 600) begin
      tick();
      cycles++;
    end
    checkOutput("t7_len", cycles, 510);
    checkOutput("t7_aborted", aborted, 0);
    tick();
    checkOutput("t7_ready", cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
